mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported memory_unit (fetch = port 0, load/store = port 1).
// Define MEM_ARB_RR_EN for round-robin arbitration; the default is fixed priority with port 1 first.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic          p0_err,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic          p1_err,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2, DRAIN = 2'd3} state_t;

  state_t        state_r, state_s;
  logic          mem_req_r, mem_req_s, mem_we_r, mem_we_s;
  logic [AW-1:0] mem_addr_r, mem_addr_s, sel_addr_s;
  logic [DW-1:0] mem_wdata_r, mem_wdata_s, sel_wdata_s;
  logic          p0_ack_r, p0_ack_s, p0_err_r, p0_err_s;
  logic          p1_ack_r, p1_ack_s, p1_err_r, p1_err_s;
  logic [DW-1:0] p0_rdata_r, p0_rdata_s, p1_rdata_r, p1_rdata_s;
  logic          grant_r, grant_s, busy_r;
  logic          win_s, sel_we_s, arb_s;
`ifdef MEM_ARB_RR_EN
  logic          last_r;
`endif

  // Winner selection and mux of the winner's request fields
  always_comb begin
`ifdef MEM_ARB_RR_EN
    if (p0_req && p1_req) begin
      win_s = ~last_r;
    end else begin
      win_s = p1_req;
    end
`else
    win_s = p1_req;
`endif
    if (win_s) begin
      sel_we_s    = p1_we;
      sel_addr_s  = p1_addr;
      sel_wdata_s = p1_wdata;
    end else begin
      sel_we_s    = p0_we;
      sel_addr_s  = p0_addr;
      sel_wdata_s = p0_wdata;
    end
  end

  // Next-state and next-output logic; all outputs are registered from these values
  always_comb begin
    state_s     = state_r;
    mem_req_s   = mem_req_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    p0_ack_s    = 1'b0;
    p0_err_s    = 1'b0;
    p0_rdata_s  = '0;
    p1_ack_s    = 1'b0;
    p1_err_s    = 1'b0;
    p1_rdata_s  = '0;
    grant_s     = grant_r;
    arb_s       = 1'b0;
    case (state_r)
      IDLE: arb_s = 1'b1;
      ISSUE: begin
        if (mem_ack) begin
          state_s     = RESP;
          mem_req_s   = 1'b0;
          mem_we_s    = 1'b0;
          mem_addr_s  = '0;
          mem_wdata_s = '0;
          if (grant_r) begin
            p1_ack_s   = 1'b1;
            p1_rdata_s = mem_we_r ? '0 : mem_rdata;
          end else begin
            p0_ack_s   = 1'b1;
            p0_rdata_s = mem_we_r ? '0 : mem_rdata;
          end
        end else begin
          state_s = ISSUE;
        end
      end
      RESP: state_s = DRAIN;
      DRAIN: begin
        // memory_unit's ack lags mem_req by a cycle; never reissue until it has fallen
        if (!mem_ack) begin
          arb_s = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
    if (arb_s) begin
      if (p0_req || p1_req) begin
        grant_s = win_s;
        if (sel_addr_s[1:0] == 2'b00) begin
          state_s     = ISSUE;
          mem_req_s   = 1'b1;
          mem_we_s    = sel_we_s;
          mem_addr_s  = sel_addr_s;
          mem_wdata_s = sel_wdata_s;
        end else begin
          state_s = RESP;
          if (win_s) begin
            p1_ack_s = 1'b1;
            p1_err_s = 1'b1;
          end else begin
            p0_ack_s = 1'b1;
            p0_err_s = 1'b1;
          end
        end
      end else begin
        state_s = IDLE;
      end
    end else begin
      grant_s = grant_r;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      p0_ack_r    <= 1'b0;
      p0_err_r    <= 1'b0;
      p0_rdata_r  <= '0;
      p1_ack_r    <= 1'b0;
      p1_err_r    <= 1'b0;
      p1_rdata_r  <= '0;
      grant_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      p0_ack_r    <= p0_ack_s;
      p0_err_r    <= p0_err_s;
      p0_rdata_r  <= p0_rdata_s;
      p1_ack_r    <= p1_ack_s;
      p1_err_r    <= p1_err_s;
      p1_rdata_r  <= p1_rdata_s;
      grant_r     <= grant_s;
      busy_r      <= (state_s != IDLE);
    end
  end

`ifdef MEM_ARB_RR_EN
  // Round-robin pointer: remembers the port of every grant, error grants included
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (arb_s && (p0_req || p1_req)) begin
      last_r <= win_s;
    end else begin
      last_r <= last_r;
    end
  end
`endif

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign p0_ack    = p0_ack_r;
  assign p0_err    = p0_err_r;
  assign p0_rdata  = p0_rdata_r;
  assign p1_ack    = p1_ack_r;
  assign p1_err    = p1_err_r;
  assign p1_rdata  = p1_rdata_r;
  assign busy      = busy_r;
  assign grant     = grant_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural memory_unit model.
// Contention expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_ack, p0_err, p1_ack, p1_err;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, grant;

  int compared = 0;
  int mismatched = 0;
  int starts = 0;
  int overlaps = 0;
  logic prev_req = 1'b0;
  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
  );

  // memory_unit model: registered ack that follows mem_req, preload applied during reset
  always @(posedge clk) begin
    if (rst) begin
      mem_ack   <= 1'b0;
      mem_rdata <= 32'h0;
      mem[0]    <= 32'h1111_0000;
      mem[1]    <= 32'h2222_0004;
      mem[4]    <= 32'hDEAD_BEEF;
    end else begin
      mem_ack <= mem_req;
      if (mem_req) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:2]];
      end
    end
  end

  // Count memory accesses and any new request raised while ack is still high
  always @(posedge clk) begin
    if (mem_req && !prev_req) begin
      starts <= starts + 1;
      if (mem_ack) overlaps <= overlaps + 1;
    end
    prev_req <= mem_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input bit port, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((port ? p1_ack : p0_ack) === 1'b1) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) chk("ack_timeout", 32'(port ? p1_ack : p0_ack), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100000");
    $fatal(1);
  end

  initial begin
    int cyc, n, nexp, s0;
    int exp_g[4];
    int exp_c[4];
    rst = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_acks", {30'd0, p1_ack, p0_ack}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // p0 read of word 4, cycle by cycle
    p0_req = 1'b1; p0_addr = 32'h10;
    @(negedge clk);
    chk("t1_mem_req_e0", 32'(mem_req), 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_grant", 32'(grant), 32'd0);
    chk("t1_early_ack", 32'(p0_ack), 32'd0);
    @(negedge clk);
    chk("t1_mem_req_e1", 32'(mem_req), 32'd1);
    chk("t1_ack_e1", 32'(p0_ack), 32'd0);
    @(negedge clk);
    chk("t1_ack_e2", 32'(p0_ack), 32'd1);
    chk("t1_rdata", p0_rdata, 32'hDEAD_BEEF);
    chk("t1_err", 32'(p0_err), 32'd0);
    chk("t1_mem_req_drop", 32'(mem_req), 32'd0);
    p0_req = 1'b0;
    @(negedge clk);
    chk("t1_ack_e3", 32'(p0_ack), 32'd0);
    chk("t1_rdata_clr", p0_rdata, 32'h0);
    chk("t1_busy_drain", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // p1 write then p0 read back
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h40; p1_wdata = 32'h1234_5678;
    wait_ack(1'b1, cyc);
    chk("t2_wr_latency", 32'(cyc), 32'd3);
    chk("t2_wr_rdata", p1_rdata, 32'h0);
    chk("t2_wr_err", 32'(p1_err), 32'd0);
    chk("t2_p0_quiet", 32'(p0_ack), 32'd0);
    p1_req = 1'b0; p1_we = 1'b0;
    wait_idle("t2_wr_idle");
    p0_req = 1'b1; p0_addr = 32'h40;
    wait_ack(1'b0, cyc);
    chk("t2_rd_rdata", p0_rdata, 32'h1234_5678);
    p0_req = 1'b0;
    wait_idle("t2_rd_idle");
    chk("t2_starts", 32'(starts), 32'd3);
    chk("t2_overlap", 32'(overlaps), 32'd0);

    // misaligned p1 read: error ack without a memory access
    s0 = starts;
    p1_req = 1'b1; p1_addr = 32'h22;
    wait_ack(1'b1, cyc);
    chk("t5_latency", 32'(cyc), 32'd1);
    chk("t5_err", 32'(p1_err), 32'd1);
    chk("t5_rdata", p1_rdata, 32'h0);
    chk("t5_grant", 32'(grant), 32'd1);
    p1_req = 1'b0;
    @(negedge clk);
    chk("t5_err_clr", {30'd0, p1_err, p1_ack}, 32'd0);
    wait_idle("t5_idle");
    chk("t5_no_mem", 32'(starts), 32'(s0));

    // reset while in ISSUE, then a fresh read
    p0_req = 1'b1; p0_addr = 32'h10;
    @(negedge clk);
    chk("t6_in_issue", 32'(mem_req), 32'd1);
    rst = 1'b1; p0_req = 1'b0;
    @(negedge clk);
    chk("t6_mem_req", 32'(mem_req), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ack", {30'd0, p1_ack, p0_ack}, 32'd0);
    chk("t6_grant", 32'(grant), 32'd0);
    chk("t6_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_no_late_ack", 32'(p0_ack), 32'd0);
    p0_req = 1'b1;
    wait_ack(1'b0, cyc);
    chk("t6_latency", 32'(cyc), 32'd3);
    chk("t6_rdata", p0_rdata, 32'hDEAD_BEEF);
    p0_req = 1'b0;
    wait_idle("t6_idle");

    // contention on reads of 0x0 (p0) and 0x4 (p1), starting from reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`ifdef MEM_ARB_RR_EN
    nexp = 4; exp_g = '{0, 1, 0, 1}; exp_c = '{3, 7, 11, 15};
`else
    nexp = 2; exp_g = '{1, 0, 0, 0}; exp_c = '{3, 7, 0, 0};
`endif
    p0_req = 1'b1; p0_addr = 32'h0; p1_req = 1'b1; p1_addr = 32'h4;
    n = 0;
    for (int c = 1; c <= 24 && n < nexp; c++) begin
      @(negedge clk);
      if (p0_ack === 1'b1 || p1_ack === 1'b1) begin
        chk($sformatf("arb_grant%0d", n), 32'(grant), 32'(exp_g[n]));
        chk($sformatf("arb_ackport%0d", n), {30'd0, p1_ack, p0_ack}, exp_g[n] ? 32'd2 : 32'd1);
        chk($sformatf("arb_cycle%0d", n), 32'(c), 32'(exp_c[n]));
        chk($sformatf("arb_rdata%0d", n), exp_g[n] ? p1_rdata : p0_rdata,
            exp_g[n] ? 32'h2222_0004 : 32'h1111_0000);
`ifndef MEM_ARB_RR_EN
        if (exp_g[n] == 1) p1_req = 1'b0; else p0_req = 1'b0;
`endif
        n++;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    chk("arb_count", 32'(n), 32'(nexp));
    wait_idle("arb_idle");
    chk("arb_overlap", 32'(overlaps), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
